countdown_timer: RTL and testbench

Tick-driven mm:ss countdown timer that consumes the one-cycle 1 Hz strobe produced by the design's clock-divider tick generator. It holds a BCD minutes/seconds value, loads it from switch inputs, and starts and pauses on a button edge. While running it decrements once per tick and flags expiry at 00:00. Its outputs feed the seven-segment display driver and the LEDs.

---
 rtl/countdown_timer.sv | 214 +++++++++++++++++++++
 tb/tb_countdown_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
// ---------------------------------------------------------------------------
// Tick-driven mm:ss countdown timer. Holds a BCD minutes/seconds value that is
// loaded from switches, started and paused by a button edge, and decremented
// once per 1 Hz tick while running. Reaching 00:00 enters DONE and pulses
// 'expired' for one cycle.
//
// Optional feature macro: ALARM_BLINK_EN
//   defined   -> 'blink' is set on entry to DONE, toggles on every tick while
//                in DONE, and clears on load or reset.
//   undefined -> 'blink' is tied low and no blink register exists.
//
// Parameters:
//   MAX_MIN    BCD ceiling for loaded minutes (default 8'h99)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-low reset
//   tick       one-cycle 1 Hz strobe, synchronous to clk
//   load       level; while high, loads the clamped min_in/sec_in every cycle
//   min_in     BCD minutes {tens, units}
//   sec_in     BCD seconds {tens, units}
//   start_btn  synchronized button level; rising edge toggles run/pause
//   min_bcd    current minutes, BCD, registered
//   sec_bcd    current seconds, BCD, registered
//   running    high in RUN
//   done       high in DONE
//   expired    one-cycle pulse on entry to DONE
//   blink      alarm blink output
// ---------------------------------------------------------------------------
module countdown_timer #(
  parameter logic [7:0] MAX_MIN = 8'h99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  input  logic       start_btn,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       blink
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       btn_q;
  logic       expired_q, expired_d;

  logic       start_edge;
  logic       value_zero;
  logic [7:0] min_clamp, sec_clamp;
  logic [7:0] min_dec, sec_dec;
  logic       dec_zero;

  // Clamp one BCD digit to an upper limit.
  function automatic logic [3:0] clampDigit(input logic [3:0] digit,
                                            input logic [3:0] limit);
    return (digit > limit) ? limit : digit;
  endfunction

  assign start_edge = start_btn & ~btn_q;
  assign value_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  // Load clamping. Digits are clamped first so the minutes byte is valid BCD,
  // which makes the plain byte comparison against MAX_MIN a numeric compare.
  always_comb begin
    logic [7:0] min_digits;
    min_digits = {clampDigit(min_in[7:4], 4'd9), clampDigit(min_in[3:0], 4'd9)};
    sec_clamp  = {clampDigit(sec_in[7:4], 4'd5), clampDigit(sec_in[3:0], 4'd9)};
    min_clamp  = (min_digits > MAX_MIN) ? MAX_MIN : min_digits;
  end

  // BCD decrement with borrow chain sec units -> sec tens -> min units ->
  // min tens. 00:00 maps to itself so the count can never wrap to 99:59.
  always_comb begin
    min_dec = min_q;
    sec_dec = sec_q;
    if (!value_zero) begin
      if (sec_q[3:0] != 4'd0) begin
        sec_dec[3:0] = sec_q[3:0] - 4'd1;
      end else begin
        sec_dec[3:0] = 4'd9;
        if (sec_q[7:4] != 4'd0) begin
          sec_dec[7:4] = sec_q[7:4] - 4'd1;
        end else begin
          sec_dec[7:4] = 4'd5;
          if (min_q[3:0] != 4'd0) begin
            min_dec[3:0] = min_q[3:0] - 4'd1;
          end else begin
            min_dec[3:0] = 4'd9;
            min_dec[7:4] = min_q[7:4] - 4'd1;
          end
        end
      end
    end
  end

  assign dec_zero = (min_dec == 8'h00) && (sec_dec == 8'h00);

`ifdef ALARM_BLINK_EN
  logic blink_q, blink_d;
`endif

  // Next-state logic. Load overrides everything. In RUN a tick decrement is
  // applied first; reaching 00:00 wins over a simultaneous start edge,
  // otherwise the start edge pauses while keeping the decremented value.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    expired_d = 1'b0;
`ifdef ALARM_BLINK_EN
    blink_d   = blink_q;
`endif
    if (load) begin
      state_d = IDLE;
      min_d   = min_clamp;
      sec_d   = sec_clamp;
`ifdef ALARM_BLINK_EN
      blink_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge && !value_zero) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            min_d = min_dec;
            sec_d = sec_dec;
          end
          if (tick && dec_zero) begin
            state_d   = DONE;
            expired_d = 1'b1;
`ifdef ALARM_BLINK_EN
            blink_d   = 1'b1;
`endif
          end else if (start_edge) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start_edge) begin
            state_d = RUN;
          end
        end
        DONE: begin
`ifdef ALARM_BLINK_EN
          if (tick) begin
            blink_d = ~blink_q;
          end
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and value registers. btn_q resets high so a button held through
  // reset is not seen as a fresh press when reset releases.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      btn_q     <= 1'b1;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      btn_q     <= start_btn;
      expired_q <= expired_d;
    end
  end

`ifdef ALARM_BLINK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign min_bcd = min_q;
  assign sec_bcd = sec_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// ---------------------------------------------------------------------------
// Self-checking bench for countdown_timer. A main instance uses the default
// MAX_MIN; a second instance with MAX_MIN = 8'h30 shares all inputs and is
// only compared where a load exceeds its ceiling. Blink expectations follow
// ALARM_BLINK_EN.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

`ifdef ALARM_BLINK_EN
  localparam logic BLINK_EN = 1'b1;
`else
  localparam logic BLINK_EN = 1'b0;
`endif

  typedef struct {
    logic       ld;
    logic [7:0] minIn;
    logic [7:0] secIn;
    logic       btn;
    logic       tk;
    logic [7:0] expMin;
    logic [7:0] expSec;
    logic       expRun;
    logic       expDone;
    logic       expExp;
    logic       expBlink;
    logic       chkAlt;
    logic [7:0] altMin;
    logic [7:0] altSec;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       load;
  logic [7:0] minIn;
  logic [7:0] secIn;
  logic       startBtn;
  logic [7:0] minBcd, secBcd;
  logic       running, done, expired, blink;
  logic [7:0] altMinBcd, altSecBcd;
  logic       altRunning, altDone, altExpired, altBlink;

  int checkCount = 0;
  int passCount  = 0;
  vec_t vecs[$];

  countdown_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .min_in(minIn), .sec_in(secIn), .start_btn(startBtn),
    .min_bcd(minBcd), .sec_bcd(secBcd), .running(running),
    .done(done), .expired(expired), .blink(blink)
  );

  countdown_timer #(.MAX_MIN(8'h30)) dutAlt (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .min_in(minIn), .sec_in(secIn), .start_btn(startBtn),
    .min_bcd(altMinBcd), .sec_bcd(altSecBcd), .running(altRunning),
    .done(altDone), .expired(altExpired), .blink(altBlink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string what, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", what, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; outputs are checked on the following negedge.
  task automatic driveCycle(input logic ld, input logic [7:0] mi,
                            input logic [7:0] si, input logic btn,
                            input logic tk);
    load     = ld;
    minIn    = mi;
    secIn    = si;
    startBtn = btn;
    tick     = tk;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    driveCycle(v.ld, v.minIn, v.secIn, v.btn, v.tk);
    checkOutput($sformatf("v%0d min", idx), minBcd, v.expMin);
    checkOutput($sformatf("v%0d sec", idx), secBcd, v.expSec);
    checkOutput($sformatf("v%0d running", idx), {7'd0, running}, {7'd0, v.expRun});
    checkOutput($sformatf("v%0d done", idx), {7'd0, done}, {7'd0, v.expDone});
    checkOutput($sformatf("v%0d expired", idx), {7'd0, expired}, {7'd0, v.expExp});
    checkOutput($sformatf("v%0d blink", idx), {7'd0, blink}, {7'd0, v.expBlink});
    if (v.chkAlt) begin
      checkOutput($sformatf("v%0d alt min", idx), altMinBcd, v.altMin);
      checkOutput($sformatf("v%0d alt sec", idx), altSecBcd, v.altSec);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [7:0] mi,
                              input logic [7:0] si, input logic btn,
                              input logic tk, input logic [7:0] eMin,
                              input logic [7:0] eSec, input logic eRun,
                              input logic eDone, input logic eExp,
                              input logic eBlink);
    vec_t v;
    v.ld = ld; v.minIn = mi; v.secIn = si; v.btn = btn; v.tk = tk;
    v.expMin = eMin; v.expSec = eSec; v.expRun = eRun; v.expDone = eDone;
    v.expExp = eExp; v.expBlink = eBlink;
    v.chkAlt = 1'b0; v.altMin = 8'h00; v.altSec = 8'h00;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic expBlink;

    // Reset with the button held high.
    rst = 1'b0;
    load = 1'b0; minIn = 8'h00; secIn = 8'h00; startBtn = 1'b1; tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset min", minBcd, 8'h00);
    checkOutput("reset sec", secBcd, 8'h00);
    checkOutput("reset running", {7'd0, running}, 8'h00);
    checkOutput("reset done", {7'd0, done}, 8'h00);
    checkOutput("reset expired", {7'd0, expired}, 8'h00);
    checkOutput("reset blink", {7'd0, blink}, 8'h00);

    // Release reset with the button still held: no edge.
    rst = 1'b1;
    driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("held btn running", {7'd0, running}, 8'h00);
    // Real press at 00:00 in IDLE stays idle.
    driveCycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("zero press running", {7'd0, running}, 8'h00);
    checkOutput("zero press sec", secBcd, 8'h00);

    // Load 01:00, start, first tick.
    vecs.delete();
    vecs.push_back(mk(1, 8'h01, 8'h00, 0, 0, 8'h01, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h59, 1, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // 58 more ticks bring the count to 00:01.
    for (int i = 0; i < 58; i++) driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    checkOutput("countdown min", minBcd, 8'h00);
    checkOutput("countdown sec", secBcd, 8'h01);
    checkOutput("countdown running", {7'd0, running}, 8'h01);
    checkOutput("countdown done", {7'd0, done}, 8'h00);

    // Final tick enters DONE with a one-cycle expired pulse.
    driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    checkOutput("expiry sec", secBcd, 8'h00);
    checkOutput("expiry done", {7'd0, done}, 8'h01);
    checkOutput("expiry expired", {7'd0, expired}, 8'h01);
    checkOutput("expiry running", {7'd0, running}, 8'h00);
    checkOutput("expiry blink", {7'd0, blink}, {7'd0, BLINK_EN});
    driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("post expiry expired", {7'd0, expired}, 8'h00);
    checkOutput("post expiry done", {7'd0, done}, 8'h01);
    checkOutput("post expiry sec", secBcd, 8'h00);

    // Three ticks in DONE toggle blink (when enabled); value stays 00:00.
    expBlink = BLINK_EN;
    for (int i = 0; i < 3; i++) begin
      driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      expBlink = BLINK_EN & ~expBlink;
      checkOutput($sformatf("done tick%0d blink", i), {7'd0, blink}, {7'd0, expBlink});
      checkOutput($sformatf("done tick%0d sec", i), secBcd, 8'h00);
      driveCycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end

    // Table of loads, runs, clamps, pause/resume and DONE-over-PAUSE.
    vecs.delete();
    vecs.push_back(mk(1, 8'h10, 8'h00, 0, 0, 8'h10, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h09, 8'h59, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 8'h10, 0, 0, 8'h00, 8'h10, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h09, 1, 0, 0, 0));
    v = mk(1, 8'h7A, 8'h8C, 0, 0, 8'h79, 8'h59, 0, 0, 0, 0);
    v.chkAlt = 1'b1; v.altMin = 8'h30; v.altSec = 8'h59;
    vecs.push_back(v);
    v = mk(1, 8'h45, 8'h99, 0, 0, 8'h45, 8'h59, 0, 0, 0, 0);
    v.chkAlt = 1'b1; v.altMin = 8'h30; v.altSec = 8'h59;
    vecs.push_back(v);
    vecs.push_back(mk(1, 8'h02, 8'h05, 0, 0, 8'h02, 8'h05, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h05, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h02, 8'h05, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h04, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h04, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h02, 8'h04, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h04, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h03, 1, 0, 0, 0));
    vecs.push_back(mk(1, 8'h03, 8'h30, 1, 0, 8'h03, 8'h30, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h03, 8'h30, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00, 8'h01, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h01, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 0, 1, 1, BLINK_EN));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, BLINK_EN));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0, BLINK_EN));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 0, 1, 0, 1'b0));
    vecs.push_back(mk(1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], 100 + i);

    // Reset in the middle of a count aborts without an expired pulse.
    driveCycle(1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
    driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    checkOutput("mid reset sec", secBcd, 8'h00);
    checkOutput("mid reset expired", {7'd0, expired}, 8'h00);
    checkOutput("mid reset done", {7'd0, done}, 8'h00);
    checkOutput("mid reset running", {7'd0, running}, 8'h00);
    rst = 1'b1;
    driveCycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
